// File: rtl/serial_word_collector.sv
// Reassembles LSB-first serial words (one bit per clock, s marks bit 0) into a valid/ready holding register.
// Optional SERIAL_COLLECT_MAG_EN adds o_mag = |o_word| (two's complement magnitude, unsigned).
module serial_word_collector #(
  parameter int WIDTH = 12
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             i,
  input  logic             s,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_abt,
`ifdef SERIAL_COLLECT_MAG_EN
  output logic [WIDTH-1:0] o_mag,
`endif
  output logic             o_ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] word_s;
  logic             last_s;

`ifdef SERIAL_COLLECT_MAG_EN
  function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] m;
    if (w[WIDTH-1]) begin
      m = ~w + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      m = w;
    end
    return m;
  endfunction
`endif

  // Current shift contents with the incoming bit merged at the counter position.
  always_comb begin
    word_s        = shift_r;
    word_s[cnt_r] = i;
    last_s        = (cnt_r == CW'(WIDTH - 1));
  end

  // Word assembly state machine, holding register and status flags.
  always_ff @(posedge t_clk) begin
    if (r) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      shift_r <= {WIDTH{1'b0}};
      o_word  <= {WIDTH{1'b0}};
      o_valid <= 1'b0;
      o_abt   <= 1'b0;
      o_ovf   <= 1'b0;
`ifdef SERIAL_COLLECT_MAG_EN
      o_mag   <= {WIDTH{1'b0}};
`endif
    end else begin
      o_abt <= 1'b0;
      if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end else begin
        o_valid <= o_valid;
      end
      case (state_r)
        IDLE: begin
          if (s) begin
            shift_r <= {{(WIDTH-1){1'b0}}, i};
            cnt_r   <= CW'(1);
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (s) begin
            // A new start strobe abandons the partial word in progress.
            shift_r <= {{(WIDTH-1){1'b0}}, i};
            cnt_r   <= CW'(1);
            o_abt   <= 1'b1;
          end else if (last_s) begin
            shift_r <= word_s;
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
            if (!o_valid || o_ready) begin
              o_word  <= word_s;
              o_valid <= 1'b1;
`ifdef SERIAL_COLLECT_MAG_EN
              o_mag   <= mag_f(word_s);
`endif
            end else begin
              o_ovf <= 1'b1;
            end
          end else begin
            shift_r <= word_s;
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector (WIDTH=12): vector table plus scoreboard on accepted words.
module tb_serial_word_collector;

  localparam int W = 12;

  logic         t_clk = 1'b0;
  logic         r = 1'b1;
  logic         i = 1'b0;
  logic         s = 1'b0;
  logic         o_ready = 1'b0;
  logic [W-1:0] o_word;
  logic         o_valid;
  logic         o_abt;
  logic         o_ovf;
`ifdef SERIAL_COLLECT_MAG_EN
  logic [W-1:0] o_mag;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] mag;
  } exp_t;

  exp_t sb_q[$];
  exp_t vec[6];

  serial_word_collector #(.WIDTH(W)) dut (
    .t_clk   (t_clk),
    .r       (r),
    .i       (i),
    .s       (s),
    .o_word  (o_word),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_abt   (o_abt),
`ifdef SERIAL_COLLECT_MAG_EN
    .o_mag   (o_mag),
`endif
    .o_ovf   (o_ovf)
  );

  always #5 t_clk = ~t_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st);
    i = b;
    s = st;
    tick();
    s = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int k = 0; k < W; k++) begin
      send_bit(w[k], (k == 0));
    end
  endtask

  task automatic push(input logic [W-1:0] w, input logic [W-1:0] m);
    exp_t e;
    e.word = w;
    e.mag  = m;
    sb_q.push_back(e);
  endtask

  // Scoreboard: each cycle showing valid&ready is one acceptance at the next edge.
  always @(negedge t_clk) begin
    if (!r && o_valid && o_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_accept", 32'(o_word), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_word", 32'(o_word), 32'(e.word));
`ifdef SERIAL_COLLECT_MAG_EN
        check("sb_mag", 32'(o_mag), 32'(e.mag));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec[0] = '{word: 12'hCB5, mag: 12'h34B};
    vec[1] = '{word: 12'h000, mag: 12'h000};
    vec[2] = '{word: 12'hFFF, mag: 12'h001};
    vec[3] = '{word: 12'h800, mag: 12'h800};
    vec[4] = '{word: 12'h7FF, mag: 12'h7FF};
    vec[5] = '{word: 12'h123, mag: 12'h123};

    // Reset held two cycles with s and i high.
    r = 1'b1; s = 1'b1; i = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_word", 32'(o_word), 32'd0);
    check("rst_abt", 32'(o_abt), 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);
`ifdef SERIAL_COLLECT_MAG_EN
    check("rst_mag", 32'(o_mag), 32'd0);
`endif
    r = 1'b0; s = 1'b0; i = 1'b0;
    tick();

    // Table of back-to-back words with the consumer always ready.
    o_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      push(vec[v].word, vec[v].mag);
      send_word(vec[v].word);
      check("tbl_valid", 32'(o_valid), 32'd1);
      check("tbl_word", 32'(o_word), 32'(vec[v].word));
`ifdef SERIAL_COLLECT_MAG_EN
      check("tbl_mag", 32'(o_mag), 32'(vec[v].mag));
`endif
    end
    tick();
    check("tbl_drain_valid", 32'(o_valid), 32'd0);
    check("tbl_ovf", 32'(o_ovf), 32'd0);

    // Back-to-back with stalled consumer: second word dropped.
    o_ready = 1'b0;
    send_word(12'h001);
    check("stall_valid1", 32'(o_valid), 32'd1);
    send_word(12'h800);
    check("stall_word", 32'(o_word), 32'h001);
    check("stall_valid2", 32'(o_valid), 32'd1);
    check("stall_ovf", 32'(o_ovf), 32'd1);
    tick(); tick();
    check("stall_ovf_held", 32'(o_ovf), 32'd1);
    push(12'h001, 12'h001);
    o_ready = 1'b1;
    tick();
    check("stall_release_valid", 32'(o_valid), 32'd0);
    check("stall_release_word", 32'(o_word), 32'h001);
    push(12'h800, 12'h800);
    send_word(12'h800);
    check("fresh_word", 32'(o_word), 32'h800);
`ifdef SERIAL_COLLECT_MAG_EN
    check("fresh_mag", 32'(o_mag), 32'h800);
`endif
    tick();
    check("ovf_sticky", 32'(o_ovf), 32'd1);
    r = 1'b1; tick(); r = 1'b0;
    check("ovf_cleared", 32'(o_ovf), 32'd0);

    // Abort: restart at bit 5 of a partial word, then a full 0x0F0.
    for (int k = 0; k < 5; k++) begin
      send_bit(1'b1, (k == 0));
    end
    check("abt_idle", 32'(o_abt), 32'd0);
    push(12'h0F0, 12'h0F0);
    for (int k = 0; k < W; k++) begin
      logic [W-1:0] w;
      w = 12'h0F0;
      send_bit(w[k], (k == 0));
      if (k == 0) begin
        check("abt_pulse", 32'(o_abt), 32'd1);
        check("abt_no_valid", 32'(o_valid), 32'd0);
      end else if (k == 1) begin
        check("abt_single", 32'(o_abt), 32'd0);
      end
    end
    check("abt_word", 32'(o_word), 32'h0F0);
    check("abt_valid", 32'(o_valid), 32'd1);
    tick();

    // Accept and complete on the same edge.
    o_ready = 1'b0;
    send_word(12'h2AA);
    check("sim_hold_valid", 32'(o_valid), 32'd1);
    push(12'h2AA, 12'h2AA);
    push(12'h555, 12'h555);
    for (int k = 0; k < W; k++) begin
      logic [W-1:0] w;
      w = 12'h555;
      if (k == W - 1) o_ready = 1'b1;
      send_bit(w[k], (k == 0));
    end
    check("sim_valid", 32'(o_valid), 32'd1);
    check("sim_word", 32'(o_word), 32'h555);
    check("sim_ovf", 32'(o_ovf), 32'd0);
    tick();

    // Reset mid-word, then a full 0xAAA with no abort pulse.
    for (int k = 0; k < 6; k++) begin
      send_bit(1'b1, (k == 0));
    end
    r = 1'b1; tick(); r = 1'b0;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    push(12'hAAA, 12'h556);
    for (int k = 0; k < W; k++) begin
      logic [W-1:0] w;
      w = 12'hAAA;
      send_bit(w[k], (k == 0));
      if (k == 0) check("mid_rst_abt", 32'(o_abt), 32'd0);
    end
    check("mid_rst_word", 32'(o_word), 32'hAAA);
    check("mid_rst_valid2", 32'(o_valid), 32'd1);
    tick(); tick();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Receive end of the LSB-first serial two's-complement datapath.
- Takes the serial bit stream produced by the bit-serial complementer (one bit per clock, LSB first) plus a start-of-word strobe.
- Reassembles WIDTH-bit parallel words and presents each on a valid/ready output port with a one-word holding register.
- Sits between the serial complementer output and any parallel consumer (register file, bus, checker).

Parameters:
- WIDTH, 12, word length in bits; legal range 2..32.

Ports:
- t_clk  input  1  clock; all state changes on the rising edge.
- r  input  1  synchronous reset, active-high.
- i  input  1  serial data bit, LSB first, sampled every t_clk edge.
- s  input  1  start-of-word strobe; high in the same cycle as bit 0 of a word.
- o_word  output  WIDTH  assembled word, bit k = k-th received bit.
- o_valid  output  1  o_word holds a complete, unconsumed word.
- o_ready  input  1  consumer accepts o_word when o_valid && o_ready at an edge.
- o_abt  output  1  one-cycle pulse: a partial word was discarded by a new s.
- o_ovf  output  1  sticky: a completed word was dropped because the holding register was full.

Behaviour:
- Reset (r=1 at an edge; overrides all other inputs):
  - State goes to IDLE, bit counter to 0, shift register to 0.
  - o_word=0, o_valid=0, o_abt=0, o_ovf=0.
  - Reset mid-word discards the partial word with no o_abt pulse.
- States:
  - IDLE: i ignored while s=0. s=1 stores i as bit 0, counter=1, goes to SHIFT. If WIDTH bits are completed in this cycle (impossible for WIDTH>=2), the completion rule applies.
  - SHIFT, s=0: stores i at bit position counter, counter+1.
  - SHIFT, bit WIDTH-1 stored: word complete, counter=0, next state IDLE.
  - SHIFT, s=1: partial word discarded; i stored as new bit 0, counter=1, stays in SHIFT; o_abt=1 for the next cycle only.
- Back-to-back words: s may be high the cycle immediately after the last bit of the previous word; no gap cycle required.
- Completion (evaluated at the edge storing bit WIDTH-1):
  - o_valid=0, or o_valid=1 with o_ready=1: o_word loads the new word and o_valid=1 from the next cycle. Latency is one cycle from the last-bit edge to o_valid.
  - o_valid=1 with o_ready=0: new word dropped, o_word unchanged, o_ovf set to 1 and held until r.
- Handshake:
  - o_valid and o_word are held stable until accepted.
  - Acceptance with no simultaneous completion clears o_valid next cycle; o_word keeps its last value.
  - o_ready while o_valid=0 has no effect.
- Counter is clog2(WIDTH) bits and never exceeds WIDTH-1; no wrap-around past WIDTH.
- No arithmetic on the data; bits are stored verbatim. Sign interpretation is the consumer's job (two's complement).

Optional Feature:
- Macro: SERIAL_COLLECT_MAG_EN.
- Defined: adds output port o_mag (WIDTH, unsigned) = |o_word| as two's complement, updated together with o_word.
  - Reset value 0.
  - Most-negative input (only MSB set) gives o_mag = 2^(WIDTH-1); this fits unsigned, no saturation.
  - Computed bit-serially during SHIFT (invert-after-first-1 rule applied once the sign is known at the last bit) or combinationally from o_word; either is legal if the cycle timing matches o_word.
- Undefined: port o_mag absent; no extra logic.

Test Plan:
- Reset: hold r=1 for 2 cycles with s=1, i=1 -> o_valid=0, o_word=0, o_abt=0, o_ovf=0.
- Basic word, WIDTH=12, o_ready=1: s=1 with bit 0, then bits 1,0,1,0,1,1,0,1,0,0,1,1 LSB first.
  - o_valid=1 one cycle after the 12th bit, o_word=0xCB5.
  - With SERIAL_COLLECT_MAG_EN defined, o_mag=0x34B.
- Back-to-back plus stall:
  - Send 0x001 then immediately 0x800 with o_ready=0 -> o_word=0x001 held, o_valid=1.
  - Second word dropped, o_ovf=1 and held; raise o_ready -> o_valid=0 next cycle.
  - With SERIAL_COLLECT_MAG_EN, a fresh 0x800 accepted -> o_mag=0x800.
- Abort: s=1 at bit 5 of a word, then a full 0x0F0 -> o_abt single-cycle pulse, o_word=0x0F0, no output for the aborted word.
- Simultaneous accept and complete: o_valid=1 with o_ready=1 on the edge completing 0x555 -> o_valid stays 1, o_word=0x555, o_ovf=0.
- Reset mid-word: r=1 after 6 bits, then a full 0xAAA -> o_word=0xAAA, o_abt=0.
